// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with byte enables, write forwarding and busy scoreboard
//
// Purpose: 2**AW x WIDTH register file (register 0 reads as zero) with
// byte-enabled writes, optional write-to-read forwarding, and a pending-write
// scoreboard set at issue and cleared at writeback.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset (clears data and busy bits)
//   we, rw, din, be  write port: enable, address, data, per-byte enables
//   rs, rt           read addresses for ports A and B
//   a, b             combinational read data for rs and rt
//   iss, ird         issue strobe and destination register to mark busy
//   rs_busy, rt_busy pending-write flags for rs and rt
module regfile_sb #(
   parameter int WIDTH  = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [AW-1:0]      rw,
   input  logic [WIDTH-1:0]   din,
   input  logic [WIDTH/8-1:0] be,
   input  logic [AW-1:0]      rs,
   input  logic [AW-1:0]      rt,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   input  logic               iss,
   input  logic [AW-1:0]      ird,
   output logic               rs_busy,
   output logic               rt_busy
);

   localparam int NB    = WIDTH / 8;
   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;

   logic [WIDTH-1:0] mask;
   logic             wr_ok;
   logic             fwd_a;
   logic             fwd_b;
   logic             clr_a;
   logic             clr_b;

   // Expand byte enables into a bit mask for merging.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NB; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
   end

   assign wr_ok = we && (rw != '0);

   // Forwarding is disabled during reset so reads show the array contents.
   assign fwd_a = (BYPASS != 0) && !rst && wr_ok && (rs == rw);
   assign fwd_b = (BYPASS != 0) && !rst && wr_ok && (rt == rw);

   // A forwarded write only hides busy if it actually clears the bit, i.e.
   // no new issue to the same register is superseding it this cycle.
   assign clr_a = fwd_a && !(iss && (ird == rw));
   assign clr_b = fwd_b && !(iss && (ird == rw));

   always_comb begin
      a = '0;
      b = '0;
      if (rs != '0) begin
         a = fwd_a ? ((regs[rs] & ~mask) | (din & mask)) : regs[rs];
      end
      if (rt != '0) begin
         b = fwd_b ? ((regs[rt] & ~mask) | (din & mask)) : regs[rt];
      end
   end

   assign rs_busy = busy[rs] && !clr_a;
   assign rt_busy = busy[rt] && !clr_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (wr_ok) begin
            regs[rw] <= (regs[rw] & ~mask) | (din & mask);
            busy[rw] <= 1'b0;
         end
         // Issue is assigned last so it wins over a same-register writeback.
         if (iss && (ird != '0)) begin
            busy[ird] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (BYPASS=1 and BYPASS=0 instances)
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [4:0]  rw = '0;
   logic [31:0] din = '0;
   logic [3:0]  be = '0;
   logic [4:0]  rs = '0;
   logic [4:0]  rt = '0;
   logic        iss = 1'b0;
   logic [4:0]  ird = '0;

   logic [31:0] a1, b1, a0, b0;
   logic        rsb1, rtb1, rsb0, rtb0;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_reg [32];
   bit          m_busy [32];

   always #5 clk = ~clk;

   regfile_sb #(.WIDTH(32), .AW(5), .BYPASS(1)) dut_byp (
      .clk(clk), .rst(rst), .we(we), .rw(rw), .din(din), .be(be),
      .rs(rs), .rt(rt), .a(a1), .b(b1), .iss(iss), .ird(ird),
      .rs_busy(rsb1), .rt_busy(rtb1)
   );

   regfile_sb #(.WIDTH(32), .AW(5), .BYPASS(0)) dut_nobyp (
      .clk(clk), .rst(rst), .we(we), .rw(rw), .din(din), .be(be),
      .rs(rs), .rt(rt), .a(a0), .b(b0), .iss(iss), .ird(ird),
      .rs_busy(rsb0), .rt_busy(rtb0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] e);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (e[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Value a read port should show this cycle.
   function automatic logic [31:0] exp_rd(input logic [4:0] adr, input bit byp);
      if (adr == 0) return 32'h0;
      if (byp && !rst && we && rw == adr) return merge(m_reg[adr], din, be);
      return m_reg[adr];
   endfunction

   // Busy flag a port should show this cycle: a forwarded writeback that
   // really retires the producer hides the pending bit immediately.
   function automatic logic [31:0] exp_busy(input logic [4:0] adr, input bit byp);
      bit retiring;
      retiring = byp && !rst && we && rw != 0 && rw == adr && !(iss && ird == rw);
      return {31'b0, m_busy[adr] && !retiring};
   endfunction

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (we && rw != 0) begin
            m_reg[rw]  = merge(m_reg[rw], din, be);
            m_busy[rw] = 1'b0;
         end
         if (iss && ird != 0) m_busy[ird] = 1'b1;
      end
   endtask

   // Check all outputs of both instances mid-cycle, then advance one edge.
   task automatic cycle(input string tag);
      @(negedge clk);
      chk({tag, ":a_byp"},   a1,   exp_rd(rs, 1));
      chk({tag, ":b_byp"},   b1,   exp_rd(rt, 1));
      chk({tag, ":rsb_byp"}, {31'b0, rsb1}, exp_busy(rs, 1));
      chk({tag, ":rtb_byp"}, {31'b0, rtb1}, exp_busy(rt, 1));
      chk({tag, ":a_nob"},   a0,   exp_rd(rs, 0));
      chk({tag, ":b_nob"},   b0,   exp_rd(rt, 0));
      chk({tag, ":rsb_nob"}, {31'b0, rsb0}, exp_busy(rs, 0));
      chk({tag, ":rtb_nob"}, {31'b0, rtb0}, exp_busy(rt, 0));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 3));
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = 32'h0;
         m_busy[i] = 1'b0;
      end

      // First reset edge without checks: array contents are unknown before it.
      rst = 1'b1;
      @(posedge clk);
      model_edge();
      #1;
      rst = 1'b0;

      // Reset state
      rs = 5'd3; rt = 5'd31;
      #1 chk("reset_a", a1, 32'h0);
      chk("reset_busy", {31'b0, rsb1}, 32'h0);
      cycle("reset");

      // Write then read
      we = 1; rw = 16; din = 32'd15; be = 4'hF;
      cycle("w16");
      rw = 17; din = 32'd25; rs = 16; rt = 17;
      #1 chk("rd16", a1, 32'd15);
      chk("fwd17", b1, 32'd25);
      cycle("w17");
      we = 0;
      #1 chk("keep16", a1, 32'd15);
      chk("rd17_nob", b0, 32'd25);
      cycle("rd17");

      // Zero register
      we = 1; rw = 0; din = 32'hDEADBEEF; rs = 0; rt = 0;
      #1 chk("zero_during", a1, 32'h0);
      cycle("w0");
      we = 0; iss = 1; ird = 0;
      #1 chk("zero_after", a1, 32'h0);
      cycle("iss0");
      iss = 0;
      #1 chk("zero_busy", {31'b0, rsb1}, 32'h0);

      // Byte enables with and without bypass
      we = 1; rw = 5; din = 32'h11223344; be = 4'hF;
      cycle("w5");
      din = 32'hAABBCCDD; be = 4'b0101; rs = 5;
      #1 chk("be_fwd", a1, 32'h11BB33DD);
      chk("be_nob_pre", a0, 32'h11223344);
      cycle("be5");
      we = 0;
      #1 chk("be_after_byp", a1, 32'h11BB33DD);
      chk("be_after_nob", a0, 32'h11BB33DD);
      cycle("be5_after");

      // Scoreboarding
      iss = 1; ird = 9; rs = 9; be = 4'hF;
      cycle("iss9");
      iss = 0;
      #1 chk("busy9", {31'b0, rsb1}, 32'h1);
      cycle("idle9");
      we = 1; rw = 9; din = 32'h99; iss = 1; ird = 9;
      cycle("wb_iss9");
      iss = 0;
      #1 chk("busy9_kept_nob", {31'b0, rsb0}, 32'h1);
      chk("busy9_clr_byp", {31'b0, rsb1}, 32'h0);
      cycle("wb9");
      we = 0;
      #1 chk("busy9_clr_nob", {31'b0, rsb0}, 32'h0);
      cycle("after9");

      // Reset mid-operation
      we = 1; rw = 18; din = 32'd666;
      cycle("w18");
      we = 0; iss = 1; ird = 18;
      cycle("iss18");
      iss = 0; rs = 18;
      #1 chk("pre_rst_a", a1, 32'd666);
      chk("pre_rst_busy", {31'b0, rsb1}, 32'h1);
      rst = 1;
      cycle("rst18");
      rst = 0;
      #1 chk("post_rst_a", a1, 32'h0);
      chk("post_rst_busy", {31'b0, rsb1}, 32'h0);
      we = 1; rw = 18; din = 32'd7;
      #1 chk("w18_fwd", a1, 32'd7);
      cycle("w18b");
      we = 0;
      #1 chk("w18_after", a1, 32'd7);
      chk("w18_busy", {31'b0, rsb1}, 32'h0);
      cycle("after18");

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 49) == 0);
         we  = $urandom_range(0, 1) == 1;
         rw  = rnd_addr();
         din = $urandom;
         be  = 4'($urandom_range(0, 15));
         iss = ($urandom_range(0, 2) == 0);
         ird = rnd_addr();
         rs  = rnd_addr();
         rt  = ($urandom_range(0, 3) == 0) ? rs : rnd_addr();
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: data width in bits; legal values are multiples of 8, 8..64.
- REQ-002 SHALL have parameter AW, default 5: address width; the depth is 2**AW registers.
- REQ-003 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 gives read-old-value behaviour.
- REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
- REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
- REQ-006 SHALL have port we, input, 1: write enable.
- REQ-007 SHALL have port rw, input, AW: write address.
- REQ-008 SHALL have port din, input, WIDTH: write data.
- REQ-009 SHALL have port be, input, WIDTH/8: byte enables; bit i covers din[8i+7:8i].
- REQ-010 SHALL have ports rs and rt, input, AW each: read addresses for ports A and B.
- REQ-011 SHALL have ports a and b, output, WIDTH each: read data for rs and rt.
- REQ-012 SHALL have port iss, input, 1: issue strobe; marks register ird as pending a write.
- REQ-013 SHALL have port ird, input, AW: destination register of the issued instruction.
- REQ-014 SHALL have ports rs_busy and rt_busy, output, 1 each: the register addressed by rs or rt has a pending write.

Function
- REQ-015 SHALL hold 2**AW registers of WIDTH bits, with register 0 hardwired to zero: writes to address 0 are discarded and reads of address 0 return 0.
- REQ-016 SHALL, on each rising clk edge with we=1, rw!=0 and rst=0, update the bytes of reg[rw] whose be bit is 1 and leave the other bytes unchanged.
- REQ-017 SHALL treat we=1 with be=0 as a no-op for data, while still clearing the busy bit per REQ-022.
- REQ-018 SHALL drive a and b combinationally from the array, with zero-cycle read latency.
- REQ-019 SHALL, when BYPASS=1, rst=0, we=1 and rs==rw!=0, drive a with the merged value: din bytes where be=1 and reg[rs] bytes elsewhere. Port b SHALL behave the same way for rt.
- REQ-020 SHALL, when BYPASS=0, return the pre-edge array contents even if a write to the same address is in progress.
- REQ-021 SHALL keep a busy bitmap of 2**AW bits. On an edge with iss=1 and ird!=0, busy[ird] is set to 1.
- REQ-022 SHALL clear busy[rw] on an edge with we=1 and rw!=0.
- REQ-023 SHALL give priority to issue when iss=1, we=1 and ird==rw!=0 in the same cycle: busy stays 1, because the new producer supersedes the old one.
- REQ-024 SHALL keep busy[0] at 0 at all times.
- REQ-025 SHALL compute rs_busy and rt_busy combinationally as busy[rs] and busy[rt].
- REQ-026 SHALL, when BYPASS=1 and a write to rs clears its busy bit in the current cycle, deassert rs_busy in that same cycle, so data and busy stay coherent. rt_busy SHALL behave the same way. When BYPASS=0, busy deasserts on the cycle after the edge.
- REQ-027 SHALL allow simultaneous reads on both ports of the same address; both ports return identical data.
- REQ-028 SHALL ignore address bits beyond AW. There is no wrap-around, because the address is exactly AW bits.

Reset
- REQ-029 SHALL, on a rising edge with rst=1, clear every register to 0 and every busy bit to 0, ignoring we and iss in that cycle.
- REQ-030 SHALL suppress bypass while rst=1: a and b return the array contents, which are 0 from the first reset edge onward.
- REQ-031 SHALL handle reset asserted between issue and writeback by clearing the pending bit. A later write to that register then sees busy already 0 and leaves it 0.

Verification
- REQ-032 SHALL cover write then read: rst for 1 cycle; we=1, rw=16, din=15, be=F; next cycle rs=16 -> a=15. Then rw=17, din=25 -> reg17=25, and reg16 stays 15.
- REQ-033 SHALL cover the zero register: we=1, rw=0, din=32'hDEADBEEF; rs=0 -> a=0 both during and after the write; iss=1, ird=0 -> rs_busy=0.
- REQ-034 SHALL cover byte enables with bypass: reg5=32'h11223344; we=1, rw=5, din=32'hAABBCCDD, be=4'b0101, rs=5 in the same cycle -> a=32'h11BB33DD combinationally (BYPASS=1); reg5=32'h11BB33DD after the edge.
- REQ-035 SHALL cover BYPASS=0: the same stimulus as REQ-034 -> a=32'h11223344 before the edge and 32'h11BB33DD after it.
- REQ-036 SHALL cover scoreboarding: iss=1, ird=9 -> rs_busy=1 with rs=9. Two cycles later, we=1, rw=9 with iss=1, ird=9 -> busy stays 1. The next cycle, we=1, rw=9 with iss=0 -> rs_busy=0.
- REQ-037 SHALL cover reset mid-operation: reg18=666 and busy[18]=1; rst=1 for 1 cycle -> a=0, rs_busy=0 with rs=18. Then we=1, rw=18, din=7 -> a=7 and busy[18]=0.
